// File: rtl/cp0_reg_if.sv
// CP0 register-file bus: mtc0 write, mfc0 read, exception commit and register outputs.
// Latency: reads combinational; writes and exception updates take effect at the next clk edge.
// Backpressure: none; every write/exception presented is accepted in the cycle it is valid.
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] config_o;
  logic [31:0] prid_o;
  logic        timer_int_o;

  // pipeline side: drives requests, observes register state
  modport master (
    output we_i, waddr_i, data_i, raddr_i, int_i,
    output excepttype_i, current_inst_addr_i, is_in_delayslot_i,
    input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
    input  config_o, prid_o, timer_int_o
  );

  // CP0 side: consumes requests, publishes register state
  modport slave (
    input  we_i, waddr_i, data_i, raddr_i, int_i,
    input  excepttype_i, current_inst_addr_i, is_in_delayslot_i,
    output data_o, count_o, compare_o, status_o, cause_o, epc_o,
    output config_o, prid_o, timer_int_o
  );
endinterface

// File: rtl/cp0_reg.sv
// MIPS32 CP0 register file: Count/Compare timer, Status, Cause, EPC, PrId, Config.
// Latency: mfc0 read is combinational (pre-edge value, no bypass); updates land next edge.
// Backpressure: none. Define CP0_TIMER_EN to make Count free-running with the Compare timer.
module cp0_reg #(
  parameter logic [31:0] PRID_VAL    = 32'h004c0102,
  parameter logic [31:0] CONFIG_INIT = 32'h00008000,
  parameter logic [31:0] STATUS_INIT = 32'h10000000
) (
  input  logic      clk,
  input  logic      rst,
  cp0_reg_if.slave  bus
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

`ifdef CP0_TIMER_EN
  localparam logic [31:0] COUNT_STEP = 32'd1;
`else
  localparam logic [31:0] COUNT_STEP = 32'd0;
`endif

  logic [31:0] count_q, compare_q, status_q, cause_q, epc_q, config_q;
  logic        timer_int_q;
  logic        exc_take, exc_eret;
  logic [4:0]  exc_code;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign wr_count   = bus.we_i && (bus.waddr_i == REG_COUNT);
  assign wr_compare = bus.we_i && (bus.waddr_i == REG_COMPARE);
  assign wr_status  = bus.we_i && (bus.waddr_i == REG_STATUS);
  assign wr_cause   = bus.we_i && (bus.waddr_i == REG_CAUSE);
  assign wr_epc     = bus.we_i && (bus.waddr_i == REG_EPC);

  // decode committed exception code into take/eret and the Cause ExcCode
  always_comb begin
    exc_take = 1'b0;
    exc_eret = 1'b0;
    exc_code = 5'd0;
    case (bus.excepttype_i)
      32'h0000_0001: begin exc_take = 1'b1; exc_code = 5'h00; end
      32'h0000_0008,
      32'h0000_000a,
      32'h0000_000c,
      32'h0000_000d: begin exc_take = 1'b1; exc_code = bus.excepttype_i[4:0]; end
      32'h0000_000e: exc_eret = 1'b1;
      default: ;
    endcase
  end

  // Count and Compare: mtc0 to Count suppresses that cycle's increment
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      config_q  <= CONFIG_INIT;
    end else begin
      count_q <= wr_count ? bus.data_i : count_q + COUNT_STEP;
      if (wr_compare) compare_q <= bus.data_i;
    end
  end

`ifdef CP0_TIMER_EN
  // sticky timer request; a Compare write acknowledges it and wins over a same-cycle match
  always_ff @(posedge clk) begin
    if (rst)                                              timer_int_q <= 1'b0;
    else if (wr_compare)                                  timer_int_q <= 1'b0;
    else if ((compare_q != 32'd0) && (count_q == compare_q)) timer_int_q <= 1'b1;
  end
`else
  assign timer_int_q = 1'b0;
`endif

  // Status/Cause/EPC: mtc0 first, then exception-owned fields override
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_INIT;
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
    end else begin
      cause_q[15:10] <= bus.int_i;
      if (wr_status) status_q <= bus.data_i;
      if (wr_epc)    epc_q    <= bus.data_i;
      if (wr_cause) begin
        cause_q[9:8] <= bus.data_i[9:8];
        cause_q[22]  <= bus.data_i[22];
        cause_q[23]  <= bus.data_i[23];
      end
      if (exc_take) begin
        // nested exception (EXL already set) keeps the original EPC and BD
        if (!status_q[1]) begin
          epc_q       <= bus.is_in_delayslot_i ? bus.current_inst_addr_i - 32'd4
                                               : bus.current_inst_addr_i;
          cause_q[31] <= bus.is_in_delayslot_i;
        end
        status_q[1]  <= 1'b1;
        cause_q[6:2] <= exc_code;
      end else if (exc_eret) begin
        status_q[1] <= 1'b0;
      end
    end
  end

  // mfc0 read mux; unmapped registers read as zero
  always_comb begin
    bus.data_o = 32'd0;
    case (bus.raddr_i)
      REG_COUNT:   bus.data_o = count_q;
      REG_COMPARE: bus.data_o = compare_q;
      REG_STATUS:  bus.data_o = status_q;
      REG_CAUSE:   bus.data_o = cause_q;
      REG_EPC:     bus.data_o = epc_q;
      REG_PRID:    bus.data_o = PRID_VAL;
      REG_CONFIG:  bus.data_o = config_q;
      default:     bus.data_o = 32'd0;
    endcase
  end

  assign bus.count_o     = count_q;
  assign bus.compare_o   = compare_q;
  assign bus.status_o    = status_q;
  assign bus.cause_o     = cause_q;
  assign bus.epc_o       = epc_q;
  assign bus.config_o    = config_q;
  assign bus.prid_o      = PRID_VAL;
  assign bus.timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: reset state, timer, exceptions, eret, mtc0 priority, Cause masking.
// Latency: inputs driven 1 time unit after posedge, outputs checked at the same point.
// Backpressure: n/a; follows CP0_TIMER_EN to pick Count/timer expectations.
module tb_cp0_reg;
  localparam logic [31:0] PRID = 32'h004c0102;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  cp0_reg_if bus();

  cp0_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] dat);
    bus.we_i    = 1'b1;
    bus.waddr_i = addr;
    bus.data_i  = dat;
    step();
    bus.we_i    = 1'b0;
  endtask

  task automatic exc(input logic [31:0] code, input logic [31:0] pc, input logic ds);
    bus.excepttype_i        = code;
    bus.current_inst_addr_i = pc;
    bus.is_in_delayslot_i   = ds;
    step();
    bus.excepttype_i        = 32'd0;
    bus.is_in_delayslot_i   = 1'b0;
  endtask

  initial begin
    bus.we_i = 1'b0; bus.waddr_i = 5'd0; bus.data_i = 32'd0; bus.raddr_i = 5'd0;
    bus.int_i = 6'd0; bus.excepttype_i = 32'd0; bus.current_inst_addr_i = 32'd0;
    bus.is_in_delayslot_i = 1'b0;

    // reset state
    step(); step();
    chk("rst_count",   bus.count_o,   32'd0);
    chk("rst_compare", bus.compare_o, 32'd0);
    chk("rst_status",  bus.status_o,  32'h10000000);
    chk("rst_cause",   bus.cause_o,   32'd0);
    chk("rst_epc",     bus.epc_o,     32'd0);
    chk("rst_config",  bus.config_o,  32'h00008000);
    chk("rst_timer",   {31'd0, bus.timer_int_o}, 32'd0);
    rst = 1'b0;

    // ten idle cycles
    repeat (10) step();
`ifdef CP0_TIMER_EN
    chk("idle_count", bus.count_o, 32'd10);
`else
    chk("idle_count", bus.count_o, 32'd0);
`endif
    bus.raddr_i = 5'd15; #1; chk("rd_prid",   bus.data_o, PRID);
    bus.raddr_i = 5'd16; #1; chk("rd_config", bus.data_o, 32'h00008000);
    bus.raddr_i = 5'd0;  #1; chk("rd_unmap0", bus.data_o, 32'd0);
    bus.raddr_i = 5'd31; #1; chk("rd_unmap31", bus.data_o, 32'd0);

    // read-only registers ignore mtc0
    mtc0(5'd15, 32'd0);
    mtc0(5'd16, 32'hFFFF_FFFF);
    chk("prid_ro",   bus.prid_o,   PRID);
    chk("config_ro", bus.config_o, 32'h00008000);

    // timer: Count=5 then Compare=20
    mtc0(5'd9, 32'd5);
    chk("wr_count5", bus.count_o, 32'd5);
    mtc0(5'd11, 32'd20);
    chk("wr_compare20", bus.compare_o, 32'd20);
    bus.raddr_i = 5'd11; #1; chk("rd_compare", bus.data_o, 32'd20);
    repeat (14) step();
`ifdef CP0_TIMER_EN
    chk("cnt_at_match", bus.count_o, 32'd20);
`else
    chk("cnt_held", bus.count_o, 32'd5);
`endif
    chk("timer_pre", {31'd0, bus.timer_int_o}, 32'd0);
    step();
`ifdef CP0_TIMER_EN
    chk("timer_rise", {31'd0, bus.timer_int_o}, 32'd1);
    step();
    chk("timer_sticky", {31'd0, bus.timer_int_o}, 32'd1);
`else
    chk("timer_off", {31'd0, bus.timer_int_o}, 32'd0);
    step();
`endif
    mtc0(5'd11, 32'd100);
    chk("timer_clear", {31'd0, bus.timer_int_o}, 32'd0);
    chk("compare100",  bus.compare_o, 32'd100);

    // syscall, not in delay slot
    exc(32'h08, 32'h0000_0100, 1'b0);
    chk("sys_epc",    bus.epc_o,    32'h100);
    chk("sys_status", bus.status_o, 32'h10000002);
    chk("sys_cause",  bus.cause_o,  32'h0000_0020);

    // nested overflow: EPC/BD kept, ExcCode updated
    exc(32'h0c, 32'h0000_0200, 1'b1);
    chk("nest_epc",   bus.epc_o,   32'h100);
    chk("nest_cause", bus.cause_o, 32'h0000_0030);

    // eret clears EXL only
    exc(32'h0e, 32'h0, 1'b0);
    chk("eret_status", bus.status_o, 32'h10000000);
    chk("eret_epc",    bus.epc_o,    32'h100);

    // overflow in delay slot with EXL=0
    exc(32'h0c, 32'h0000_0200, 1'b1);
    chk("ds_epc",    bus.epc_o,    32'h1FC);
    chk("ds_cause",  bus.cause_o,  32'h8000_0030);
    chk("ds_status", bus.status_o, 32'h10000002);
    exc(32'h0e, 32'h0, 1'b0);
    chk("ds_eret_status", bus.status_o, 32'h10000000);
    chk("ds_eret_epc",    bus.epc_o,    32'h1FC);

    // unknown nonzero code changes nothing
    exc(32'h05, 32'h0000_0700, 1'b1);
    chk("unk_status", bus.status_o, 32'h10000000);
    chk("unk_epc",    bus.epc_o,    32'h1FC);
    chk("unk_cause",  bus.cause_o,  32'h8000_0030);

    // mtc0 EPC same cycle as syscall: exception wins EPC
    bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.data_i = 32'h55;
    exc(32'h08, 32'h0000_0300, 1'b0);
    bus.we_i = 1'b0;
    chk("mix_epc",   bus.epc_o,   32'h300);
    chk("mix_cause", bus.cause_o, 32'h0000_0020);
    exc(32'h0e, 32'h0, 1'b0);

    // mtc0 Status same cycle as interrupt exception: written bits kept, EXL forced
    bus.we_i = 1'b1; bus.waddr_i = 5'd12; bus.data_i = 32'h0000_ff01;
    exc(32'h01, 32'h0000_0400, 1'b0);
    bus.we_i = 1'b0;
    chk("mixs_status", bus.status_o, 32'h0000_ff03);
    chk("mixs_epc",    bus.epc_o,    32'h400);
    chk("mixs_cause",  bus.cause_o,  32'h0);
    exc(32'h0e, 32'h0, 1'b0);
    chk("mixs_eret", bus.status_o, 32'h0000_ff01);

    // EPC read reflects pre-edge value
    bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.data_i = 32'hABC; bus.raddr_i = 5'd14;
    #1; chk("rd_nobypass", bus.data_o, 32'h400);
    step(); bus.we_i = 1'b0;
    chk("rd_epc_new", bus.data_o, 32'hABC);

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    chk("cnt_max", bus.count_o, 32'hFFFF_FFFF);
    step();
`ifdef CP0_TIMER_EN
    chk("cnt_wrap", bus.count_o, 32'd0);
`else
    chk("cnt_wrap", bus.count_o, 32'hFFFF_FFFF);
`endif

    // hardware interrupt lines and Cause write mask
    bus.int_i = 6'b000001;
    step();
    chk("ip_sample", bus.cause_o, 32'h0000_0400);
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk("cause_mask", bus.cause_o, 32'h00C0_0700);
    bus.raddr_i = 5'd13; #1; chk("rd_cause", bus.data_o, 32'h00C0_0700);
    bus.int_i = 6'b100000;
    step();
    chk("ip_follow", bus.cause_o, 32'h00C0_8300);
    chk("timer_end", {31'd0, bus.timer_int_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
